modbus_frame_rx: RTL and testbench

- Request-side counterpart of the slave response transmitter: receives Modbus RTU request bytes from the UART byte receiver, delimits frames by silence timing, and checks slave address, length and CRC-16.
- Decodes function 03/04/06 requests into the func_code / start address / quantity fields that drive the response transmitter.
- Sits between the UART RX byte layer and the response/register-file logic.

---
 rtl/modbus_frame_rx.sv | 195 +++++++++++++++++++
 tb/tb_modbus_frame_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_frame_rx.sv
// Modbus RTU request receiver: silence-delimited framing, CRC-16 check and 03/04/06 decode.
// Optional MODBUS_BROADCAST_EN accepts address 00 write-single requests and adds a broadcast output.
module modbus_frame_rx #(
    parameter logic [7:0]  DEV_ADDR  = 8'h01,
    parameter int unsigned T15_CLKS  = 37500,
    parameter int unsigned T35_CLKS  = 87500,
    parameter int unsigned REG_DEPTH = 256,
    parameter int unsigned MAX_QTY   = 125
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic        rx_done,
    output logic        rx_exc,
    output logic [7:0]  exc_code,
    output logic [7:0]  func_code,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_quantity,
    output logic        frame_drop,
`ifdef MODBUS_BROADCAST_EN
    output logic        broadcast,
`endif
    output logic        rx_busy
);
    localparam int TW = $clog2(T35_CLKS + 1);
    localparam logic [TW-1:0] T35_T = TW'(T35_CLKS);
    localparam logic [TW-1:0] T15_T = TW'(T15_CLKS);
    localparam logic [16:0] DEPTH17 = 17'(REG_DEPTH);
    localparam logic [16:0] MAX17   = 17'(MAX_QTY);

    typedef enum logic [1:0] {SYNC, IDLE, RECV, CHECK} state_t;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      count_q, count_d;
    logic [15:0]     crc_q, crc_d;
    logic [5:0][7:0] frame_q, frame_d;
    logic            gap_err_q, gap_err_d;
    logic            rx_done_q, rx_done_d;
    logic            rx_exc_q, rx_exc_d;
    logic            frame_drop_q, frame_drop_d;
    logic            rx_busy_q, rx_busy_d;
    logic [7:0]      exc_code_q, exc_code_d;
    logic [7:0]      func_code_q, func_code_d;
    logic [15:0]     reg_addr_q, reg_addr_d;
    logic [15:0]     reg_quantity_q, reg_quantity_d;
`ifdef MODBUS_BROADCAST_EN
    logic            broadcast_q, broadcast_d;
`endif

    // Frame evaluation works on the registered frame, so it is valid in the last RECV cycle.
    logic [7:0]  fc, code;
    logic [16:0] addr17, qty17;
    logic        is_rd, frame_ok, unicast, bcast, accept;

    always_comb begin
        fc       = frame_q[1];
        addr17   = {1'b0, frame_q[2], frame_q[3]};
        qty17    = {1'b0, frame_q[4], frame_q[5]};
        is_rd    = (fc == 8'h03) || (fc == 8'h04);
        frame_ok = (count_q == 4'd8) && !gap_err_q && (crc_q == 16'h0000);
        code     = 8'h00;
        if (!(is_rd || fc == 8'h06))                         code = 8'h01;
        else if (is_rd && (qty17 == '0 || qty17 > MAX17))    code = 8'h03;
        else if (is_rd && (addr17 + qty17 > DEPTH17))        code = 8'h02;
        else if (fc == 8'h06 && addr17 >= DEPTH17)           code = 8'h02;
        unicast  = frame_ok && (frame_q[0] == DEV_ADDR);
`ifdef MODBUS_BROADCAST_EN
        bcast    = frame_ok && (frame_q[0] == 8'h00) && (fc == 8'h06) && (code == 8'h00);
`else
        bcast    = 1'b0;
`endif
        accept   = unicast || bcast;
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = rx_byte_valid ? '0 : ((timer_q == T35_T) ? T35_T : timer_q + TW'(1));
        count_d        = count_q;
        crc_d          = crc_q;
        frame_d        = frame_q;
        gap_err_d      = gap_err_q;
        rx_done_d      = 1'b0;
        rx_exc_d       = 1'b0;
        frame_drop_d   = 1'b0;
        exc_code_d     = exc_code_q;
        func_code_d    = func_code_q;
        reg_addr_d     = reg_addr_q;
        reg_quantity_d = reg_quantity_q;
`ifdef MODBUS_BROADCAST_EN
        broadcast_d    = broadcast_q;
`endif
        case (state_q)
            SYNC: if (timer_q == T35_T) state_d = IDLE;
            IDLE, CHECK: begin
                state_d = IDLE;
                if (rx_byte_valid) begin
                    frame_d[0] = rx_byte;
                    crc_d      = crc_upd(16'hFFFF, rx_byte);
                    count_d    = 4'd1;
                    gap_err_d  = 1'b0;
                    state_d    = RECV;
                end
            end
            RECV: begin
                if (rx_byte_valid) begin
                    for (int i = 1; i < 6; i++)
                        if (count_q == 4'(i)) frame_d[i] = rx_byte;
                    crc_d = crc_upd(crc_q, rx_byte);
                    if (count_q != 4'd9) count_d = count_q + 4'd1;
                    if (timer_q > T15_T) gap_err_d = 1'b1;
                end else if (timer_q == T35_T) begin
                    // Result pulses are registered here so they show during the CHECK cycle.
                    state_d = CHECK;
                    if (!accept) begin
                        frame_drop_d = 1'b1;
                    end else begin
                        func_code_d    = fc;
                        reg_addr_d     = {frame_q[2], frame_q[3]};
                        reg_quantity_d = {frame_q[4], frame_q[5]};
                        exc_code_d     = code;
                        rx_done_d      = (code == 8'h00);
                        rx_exc_d       = (code != 8'h00);
`ifdef MODBUS_BROADCAST_EN
                        broadcast_d    = bcast;
`endif
                    end
                end
            end
            default: state_d = SYNC;
        endcase
        rx_busy_d = (state_d == RECV) || (state_d == CHECK);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= SYNC;
            timer_q        <= '0;
            count_q        <= '0;
            crc_q          <= 16'hFFFF;
            frame_q        <= '0;
            gap_err_q      <= 1'b0;
            rx_done_q      <= 1'b0;
            rx_exc_q       <= 1'b0;
            frame_drop_q   <= 1'b0;
            rx_busy_q      <= 1'b0;
            exc_code_q     <= '0;
            func_code_q    <= '0;
            reg_addr_q     <= '0;
            reg_quantity_q <= '0;
`ifdef MODBUS_BROADCAST_EN
            broadcast_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            count_q        <= count_d;
            crc_q          <= crc_d;
            frame_q        <= frame_d;
            gap_err_q      <= gap_err_d;
            rx_done_q      <= rx_done_d;
            rx_exc_q       <= rx_exc_d;
            frame_drop_q   <= frame_drop_d;
            rx_busy_q      <= rx_busy_d;
            exc_code_q     <= exc_code_d;
            func_code_q    <= func_code_d;
            reg_addr_q     <= reg_addr_d;
            reg_quantity_q <= reg_quantity_d;
`ifdef MODBUS_BROADCAST_EN
            broadcast_q    <= broadcast_d;
`endif
        end
    end

    assign rx_done      = rx_done_q;
    assign rx_exc       = rx_exc_q;
    assign frame_drop   = frame_drop_q;
    assign rx_busy      = rx_busy_q;
    assign exc_code     = exc_code_q;
    assign func_code    = func_code_q;
    assign reg_addr     = reg_addr_q;
    assign reg_quantity = reg_quantity_q;
`ifdef MODBUS_BROADCAST_EN
    assign broadcast    = broadcast_q;
`endif
endmodule

// File: tb/tb_modbus_frame_rx.sv
// Bench for modbus_frame_rx: frame-level model checked every cycle plus literal per-frame expectations.
module tb_modbus_frame_rx;
    localparam int T15 = 30;
    localparam int T35 = 70;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_byte_valid = 1'b0;
    logic        rx_done, rx_exc, frame_drop, rx_busy;
    logic [7:0]  exc_code, func_code;
    logic [15:0] reg_addr, reg_quantity;
`ifdef MODBUS_BROADCAST_EN
    logic        broadcast;
`endif

    always #5 clk_in = ~clk_in;

    modbus_frame_rx #(.DEV_ADDR(8'h01), .T15_CLKS(T15), .T35_CLKS(T35),
                      .REG_DEPTH(256), .MAX_QTY(125)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .rx_done(rx_done), .rx_exc(rx_exc), .exc_code(exc_code), .func_code(func_code),
        .reg_addr(reg_addr), .reg_quantity(reg_quantity), .frame_drop(frame_drop),
`ifdef MODBUS_BROADCAST_EN
        .broadcast(broadcast),
`endif
        .rx_busy(rx_busy));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [0:9][7:0] f, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {8'h00, f[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Frame-level model: a frame is the bytes since start-up silence, closed by T35 cycles of quiet.
    bit          m_sync = 1'b1;
    int          m_quiet = 0, m_edge = 0, m_last = 0;
    logic [7:0]  m_q[$];
    bit          m_gap = 1'b0, m_ec_valid = 1'b0;
    logic        m_done = 0, m_exc = 0, m_drop = 0, m_busy = 0;
    logic [7:0]  m_fc = 0, m_ec = 0;
    logic [15:0] m_ra = 0, m_rq = 0;

    task automatic model_eval();
        logic [0:9][7:0] f;
        int addr, qty, code;
        logic [7:0] fc;
        f = '0;
        for (int i = 0; i < m_q.size() && i < 10; i++) f[i] = m_q[i];
        if (m_q.size() != 8 || m_gap || f[0] != 8'h01 || crc16(f, 6) != {f[7], f[6]}) begin
            m_drop = 1'b1;
            return;
        end
        fc   = f[1];
        addr = {f[2], f[3]};
        qty  = {f[4], f[5]};
        if (fc != 8'h03 && fc != 8'h04 && fc != 8'h06) code = 1;
        else if (fc == 8'h06) code = (addr >= 256) ? 2 : 0;
        else if (qty == 0 || qty > 125) code = 3;
        else if (addr + qty > 256) code = 2;
        else code = 0;
        m_fc = fc; m_ra = addr[15:0]; m_rq = qty[15:0];
        if (code == 0) begin
            m_done = 1'b1; m_ec_valid = 1'b0; m_ec = 8'h00;
        end else begin
            m_exc = 1'b1; m_ec_valid = 1'b1; m_ec = code[7:0];
        end
    endtask

    initial forever begin
        bit ended;
        @(posedge clk_in);
        m_done = 0; m_exc = 0; m_drop = 0; ended = 0;
        if (rst_in) begin
            m_sync = 1; m_quiet = 0; m_q.delete(); m_gap = 0; m_busy = 0;
            m_fc = 0; m_ra = 0; m_rq = 0; m_ec = 0; m_ec_valid = 0;
        end else begin
            if (m_sync) begin
                if (m_quiet == T35) m_sync = 0;
            end else if (rx_byte_valid) begin
                if (m_q.size() == 0) m_gap = 0;
                else if (m_edge - m_last - 1 > T15) m_gap = 1;
                m_q.push_back(rx_byte);
                m_last = m_edge;
            end else if (m_q.size() > 0 && m_edge - m_last == T35 + 1) begin
                model_eval();
                m_q.delete();
                ended = 1;
            end
            m_quiet = rx_byte_valid ? 0 : ((m_quiet < T35) ? m_quiet + 1 : T35);
            m_busy  = (m_q.size() > 0) || ended;
        end
        m_edge++;
    end

    int c_done = 0, c_exc = 0, c_drop = 0;

    initial forever begin
        @(posedge clk_in);
        #1;
        chk("rx_done", rx_done, m_done);
        chk("rx_exc", rx_exc, m_exc);
        chk("frame_drop", frame_drop, m_drop);
        chk("rx_busy", rx_busy, m_busy);
        chk("func_code", func_code, m_fc);
        chk("reg_addr", reg_addr, m_ra);
        chk("reg_quantity", reg_quantity, m_rq);
        if (m_ec_valid) chk("exc_code", exc_code, m_ec);
        if (rx_done === 1'b1) c_done++;
        if (rx_exc === 1'b1) c_exc++;
        if (frame_drop === 1'b1) c_drop++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b, input int space);
        @(negedge clk_in);
        rx_byte = b;
        rx_byte_valid = 1'b1;
        @(negedge clk_in);
        rx_byte_valid = 1'b0;
        repeat (space - 2) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [0:9][7:0] f, input int n, input bit add_crc,
                              input int gap_idx);
        logic [15:0] c;
        if (add_crc) begin
            c = crc16(f, 6);
            f[6] = c[7:0];
            f[7] = c[15:8];
        end
        for (int i = 0; i < n; i++) send_byte(f[i], (i == gap_idx) ? 40 : 12);
    endtask

    task automatic run_frame(input string name, input logic [0:9][7:0] f, input int n,
                             input bit add_crc, input int gap_idx,
                             input int e_done, input int e_exc, input int e_drop);
        int d0, x0, p0;
        d0 = c_done; x0 = c_exc; p0 = c_drop;
        send_frame(f, n, add_crc, gap_idx);
        idle(80);
        chk({name, "_done_cnt"}, c_done - d0, e_done);
        chk({name, "_exc_cnt"}, c_exc - x0, e_exc);
        chk({name, "_drop_cnt"}, c_drop - p0, e_drop);
    endtask

    initial begin
        int d0;
        idle(3);
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        chk("reset_func", func_code, 8'h00);
        chk("reset_addr", reg_addr, 16'h0000);
        chk("reset_qty", reg_quantity, 16'h0000);
        chk("reset_exc_code", exc_code, 8'h00);
        chk("reset_busy", rx_busy, 1'b0);

        // Valid frame during start-up silence must be ignored.
        run_frame("sync", 80'h01_03_00_00_00_0A_C5_CD_00_00, 8, 0, -1, 0, 0, 0);
        chk("sync_func", func_code, 8'h00);

        run_frame("f03", 80'h01_03_00_00_00_0A_C5_CD_00_00, 8, 0, -1, 1, 0, 0);
        chk("f03_func", func_code, 8'h03);
        chk("f03_addr", reg_addr, 16'h0000);
        chk("f03_qty", reg_quantity, 16'h000A);

        run_frame("f06", 80'h01_06_00_01_00_03_98_0B_00_00, 8, 0, -1, 1, 0, 0);
        chk("f06_func", func_code, 8'h06);
        chk("f06_addr", reg_addr, 16'h0001);
        chk("f06_qty", reg_quantity, 16'h0003);

        run_frame("badcrc", 80'h01_04_00_00_00_0A_70_0E_00_00, 8, 0, -1, 0, 0, 1);
        chk("badcrc_func", func_code, 8'h06);
        chk("badcrc_addr", reg_addr, 16'h0001);
        chk("badcrc_qty", reg_quantity, 16'h0003);
        run_frame("gap", 80'h01_04_00_00_00_0A_00_00_00_00, 8, 1, 3, 0, 0, 1);

        run_frame("exc01", 80'h01_05_00_00_FF_00_00_00_00_00, 8, 1, -1, 0, 1, 0);
        chk("exc01_code", exc_code, 8'h01);
        chk("exc01_func", func_code, 8'h05);
        run_frame("exc02", 80'h01_03_00_FC_00_0A_00_00_00_00, 8, 1, -1, 0, 1, 0);
        chk("exc02_code", exc_code, 8'h02);
        run_frame("exc03", 80'h01_03_00_00_00_00_00_00_00_00, 8, 1, -1, 0, 1, 0);
        chk("exc03_code", exc_code, 8'h03);
        run_frame("qty126", 80'h01_03_00_00_00_7E_00_00_00_00, 8, 1, -1, 0, 1, 0);
        chk("qty126_code", exc_code, 8'h03);
        run_frame("w_addr256", 80'h01_06_01_00_00_05_00_00_00_00, 8, 1, -1, 0, 1, 0);
        chk("w_addr256_code", exc_code, 8'h02);
        run_frame("qty125", 80'h01_04_00_00_00_7D_00_00_00_00, 8, 1, -1, 1, 0, 0);
        chk("qty125_qty", reg_quantity, 16'h007D);
        run_frame("end256", 80'h01_03_00_F6_00_0A_00_00_00_00, 8, 1, -1, 1, 0, 0);
        chk("end256_addr", reg_addr, 16'h00F6);

        run_frame("addr02", 80'h02_03_00_00_00_0A_00_00_00_00, 8, 1, -1, 0, 0, 1);
        run_frame("len9", 80'h01_03_00_00_00_0A_C5_CD_00_00, 9, 0, -1, 0, 0, 1);
        chk("len9_addr", reg_addr, 16'h00F6);

        // Reset after byte 4 of a frame, then a fresh frame after start-up silence.
        d0 = c_done;
        send_byte(8'h01, 12); send_byte(8'h03, 12); send_byte(8'h00, 12); send_byte(8'h00, 12);
        rst_in = 1'b1;
        idle(3);
        chk("midrst_func", func_code, 8'h00);
        chk("midrst_busy", rx_busy, 1'b0);
        rst_in = 1'b0;
        idle(80);
        run_frame("post_rst", 80'h01_04_00_10_00_02_00_00_00_00, 8, 1, -1, 1, 0, 0);
        chk("post_rst_total_done", c_done - d0, 1);
        chk("post_rst_func", func_code, 8'h04);
        chk("post_rst_addr", reg_addr, 16'h0010);
        chk("post_rst_qty", reg_quantity, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
